finalproject_soc_event_pio: RTL and testbench
=============================================

FINALPROJECT_SOC_EVENT_PIO -- requirements
Module: finalproject_soc_event_pio

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: address  input  2  Avalon-MM register select.
REQ-004 SHALL have port: chipselect  input  1  Avalon-MM slave select.
REQ-005 SHALL have port: read_n  input  1  active-low read strobe; single-cycle reads.
REQ-006 SHALL have port: write_n  input  1  active-low write strobe.
REQ-007 SHALL have port: writedata  input  32  write data; only the bits named below are used.
REQ-008 SHALL have port: readdata  output  32  combinational read data, zero read latency, unused bits 0.
REQ-009 SHALL have port: in_port  input  8  asynchronous hardware event lines (score, paddle hit, etc.).
REQ-010 SHALL have port: irq  output  1  level interrupt to CPU.

Function
REQ-011 SHALL sample in_port through a sync chain whose last stage is S[7:0]; register P[7:0] SHALL hold S delayed one cycle.
REQ-012 SHALL form edge vector E = S & ~P & MASK each cycle; E != 0 is an event.
REQ-013 SHALL push E into a 4-entry FIFO on the clock edge following the cycle in which E != 0.
REQ-014 Read address 0 SHALL return {24'b0, S}; writes to address 0 SHALL be ignored.
REQ-015 Read address 1 SHALL return status: bit0 = not_empty, bit1 = full, bits[4:2] = count (0..4), bit8 = overflow (sticky); all other bits 0.
REQ-016 Write address 1 with writedata[8]=1 SHALL clear overflow; writedata[8]=0 SHALL leave it unchanged.
REQ-017 Address 2 SHALL be MASK[7:0], read/write; a write SHALL load writedata[7:0].
REQ-018 Read address 3 SHALL return {not_empty, 23'b0, head[7:0]}; head SHALL read 0 when empty.
REQ-019 A read strobe at address 3 (chipselect & ~read_n) with FIFO non-empty SHALL pop one entry at that clock edge; a read when empty SHALL not change state.
REQ-020 A push when full without a same-cycle pop SHALL drop the new entry and set overflow; FIFO contents SHALL be unchanged.
REQ-021 A simultaneous push and pop SHALL occur together: count unchanged, no overflow, even when full.
REQ-022 FIFO order SHALL be first-in first-out; pointers SHALL wrap modulo 4.
REQ-023 irq SHALL be registered-state driven: irq = not_empty, with no combinational path from in_port.
REQ-024 A MASK write SHALL take effect for E in the cycle after the write edge; already-queued entries SHALL not be altered.
REQ-025 Write strobes SHALL take precedence only over their own register; concurrent event push and status/mask writes SHALL both take effect.

Reset
REQ-026 While reset is high, at each clock edge, sync stages, S, P, MASK, FIFO pointers, count and overflow SHALL be 0; readdata SHALL then reflect zeros and irq SHALL be 0.
REQ-027 in_port lines high at reset release SHALL produce no event, because MASK=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries and the overflow flag within that edge.

Configuration
REQ-029 With macro EVENT_PIO_SYNC_EN defined, the sync chain SHALL be two flops: an in_port rise is seen in S after 2 edges and pushed, with irq high, after edge 3.
REQ-030 Without EVENT_PIO_SYNC_EN, the chain SHALL be one flop: S after 1 edge, push and irq after edge 2; all other behaviour is identical.

Verification
REQ-031 Reset, then MASK=0xFF, then in_port 0x00->0x05 held -> one entry 0x05; status count=1, irq=1 at the latency in REQ-029/030; read addr3 -> 0x80000005, then irq=0.
REQ-032 MASK=0x01, in_port 0x00->0x03 -> entry 0x01; then in_port 0x03->0x02 -> no push, because falling and unmasked edges are filtered.
REQ-033 Five separated rising events with no reads -> count=4, full=1, overflow=1; pops return the first four in order; write addr1 0x100 -> overflow=0.
REQ-034 FIFO full and an event coincides with an addr3 read -> pop returns oldest, new entry appended, count stays 4, overflow stays 0.
REQ-035 Read addr3 when empty -> 0x00000000, count stays 0; assert reset with 3 entries queued -> count=0, irq=0, MASK=0 next cycle.

Source files
------------

// File: rtl/finalproject_soc_event_pio.sv
// Event-capturing PIO for the SoC: synchronises 8 hardware event lines,
// detects masked rising edges and queues each non-zero edge vector in a
// 4-entry FIFO that the CPU drains over Avalon-MM. irq is high while the
// FIFO holds at least one entry.
//
// Optional build macro: EVENT_PIO_SYNC_EN selects a two-flop input
// synchroniser; without it a single flop is used.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high
//   address    - register select (0 data, 1 status, 2 mask, 3 fifo head)
//   chipselect - slave select
//   read_n     - active-low read strobe; a read of address 3 pops the FIFO
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - combinational read data, unused bits zero
//   in_port    - asynchronous event lines
//   irq        - level interrupt, equals FIFO not-empty
module finalproject_soc_event_pio (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  in_port,
  output logic        irq
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  logic [DW-1:0] s_q;
  logic [DW-1:0] p_q;
  logic [DW-1:0] mask_q, mask_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] event_c;
  logic          push_c;
  logic          pop_c;
  logic          accept_c;
  logic          full_c;
  logic          not_empty_c;
  logic          wr_status_c;
  logic          wr_mask_c;
  logic [DW-1:0] head_c;

  // Input synchroniser; its last stage is S.
`ifdef EVENT_PIO_SYNC_EN
  logic [DW-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_q    <= '0;
    end else begin
      sync_q <= in_port;
      s_q    <= sync_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) s_q <= '0;
    else       s_q <= in_port;
  end
`endif

  // FIFO control, mask and overflow next-state.
  always_comb begin
    event_c     = s_q & ~p_q & mask_q;
    push_c      = |event_c;
    not_empty_c = (count_q != '0);
    full_c      = (count_q == CW'(DEPTH));
    pop_c       = chipselect & ~read_n & (address == 2'd3) & not_empty_c;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    accept_c    = push_c & (~full_c | pop_c);
    wr_status_c = chipselect & ~write_n & (address == 2'd1);
    wr_mask_c   = chipselect & ~write_n & (address == 2'd2);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;

    if (accept_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)    rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(accept_c) - CW'(pop_c);

    if (wr_status_c && writedata[8]) ovf_d = 1'b0;
    // A fresh drop wins over a same-cycle clear.
    if (push_c && !accept_c)         ovf_d = 1'b1;
    if (wr_mask_c)                   mask_d = writedata[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q      <= '0;
      mask_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      p_q      <= s_q;
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (accept_c) mem_q[wr_ptr_q] <= event_c;
  end

  // Zero-latency read mux.
  always_comb begin
    head_c   = not_empty_c ? mem_q[rd_ptr_q] : '0;
    readdata = '0;
    unique case (address)
      2'd0: readdata = {24'b0, s_q};
      2'd1: readdata = {23'b0, ovf_q, 3'b0, count_q, full_c, not_empty_c};
      2'd2: readdata = {24'b0, mask_q};
      2'd3: readdata = {not_empty_c, 23'b0, head_c};
      default: readdata = '0;
    endcase
  end

  assign irq = not_empty_c;

  logic unused_c;
  assign unused_c = ^{writedata[31:9]};

endmodule

// File: tb/tb_finalproject_soc_event_pio.sv
// Self-checking bench for finalproject_soc_event_pio: directed scenarios
// followed by randomized bus/event traffic, all compared against a
// queue-based reference model.
module tb_finalproject_soc_event_pio;

`ifdef EVENT_PIO_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  always #5 clk = ~clk;

  finalproject_soc_event_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int errors = 0;
  int checks = 0;
  bit primed = 1'b0;
  logic [31:0] rd_obs;

  // Reference model: FIFO as a queue, in_port sample history as a queue
  // (index 0 = newest sample), mask and overflow as plain variables.
  logic [7:0] m_fifo[$];
  logic [7:0] m_hist[$];
  logic [7:0] m_mask = 8'h00;
  bit         m_ovf  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    int n;
    logic [31:0] r;
    n = m_fifo.size();
    r = 32'h0;
    case (a)
      2'd0: r = {24'b0, m_hist[L-1]};
      2'd1: r = (m_ovf ? 32'h100 : 32'h0) | (32'(n) << 2) |
                ((n == 4) ? 32'h2 : 32'h0) | ((n != 0) ? 32'h1 : 32'h0);
      2'd2: r = {24'b0, m_mask};
      default: r = (n != 0) ? {1'b1, 23'b0, m_fifo[0]} : 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [7:0] e;
    if (reset) begin
      m_fifo.delete();
      m_hist.delete();
      for (int i = 0; i <= L; i++) m_hist.push_back(8'h00);
      m_mask = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      e = m_hist[L-1] & ~m_hist[L] & m_mask;
      if (chipselect && !read_n && address == 2'd3 && m_fifo.size() > 0)
        void'(m_fifo.pop_front());
      if (chipselect && !write_n && address == 2'd1 && writedata[8])
        m_ovf = 1'b0;
      if (e != 8'h00) begin
        if (m_fifo.size() < 4) m_fifo.push_back(e);
        else                   m_ovf = 1'b1;
      end
      if (chipselect && !write_n && address == 2'd2)
        m_mask = writedata[7:0];
      m_hist.push_front(in_port);
      void'(m_hist.pop_back());
    end
  endtask

  // One bus cycle: called just after a falling edge with inputs set.
  task automatic tick();
    #1;
    rd_obs = readdata;
    if (primed) check_eq($sformatf("rdata_a%0d", address), readdata, m_read(address));
    model_edge();
    @(posedge clk);
    if (reset) primed = 1'b1;
    #1;
    if (primed) check_eq("irq", {31'b0, irq}, {31'b0, (m_fifo.size() != 0)});
    @(negedge clk);
  endtask

  task automatic cyc(input bit rst, input bit cs, input bit rn, input bit wn,
                     input logic [1:0] a, input logic [31:0] d);
    reset = rst; chipselect = cs; read_n = rn; write_n = wn;
    address = a; writedata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) begin
      in_port = 8'h00; idle(3);
      in_port = 8'(i);  idle(3);
    end
  endtask

  initial begin
    for (int i = 0; i <= L; i++) m_hist.push_back(8'h00);
    in_port = 8'h00;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    rd(2'd1);
    check_eq("reset_status", rd_obs, 32'h0);
    check_eq("reset_irq", {31'b0, irq}, 32'h0);

    // Single masked event and its latency.
    wr(2'd2, 32'hFF);
    idle(3);
    in_port = 8'h05;
    idle(L);
    check_eq("lat_irq_lo", {31'b0, irq}, 32'h0);
    idle(1);
    check_eq("lat_irq_hi", {31'b0, irq}, 32'h1);
    rd(2'd1);
    check_eq("one_status", rd_obs, 32'h5);
    rd(2'd3);
    check_eq("one_pop", rd_obs, 32'h8000_0005);
    check_eq("one_irq_clr", {31'b0, irq}, 32'h0);

    // Mask and falling-edge filtering.
    wr(2'd2, 32'h01);
    in_port = 8'h00; idle(3);
    in_port = 8'h03; idle(L + 1);
    rd(2'd3);
    check_eq("mask_pop", rd_obs, 32'h8000_0001);
    in_port = 8'h02; idle(4);
    rd(2'd1);
    check_eq("fall_status", rd_obs, 32'h0);

    // Overflow after five events, FIFO order, sticky clear.
    wr(2'd2, 32'hFF);
    fill(5);
    rd(2'd1);
    check_eq("ovf_status", rd_obs, 32'h113);
    for (int i = 1; i <= 4; i++) begin
      rd(2'd3);
      check_eq($sformatf("ovf_pop%0d", i), rd_obs, 32'h8000_0000 | 32'(i));
    end
    rd(2'd1);
    check_eq("ovf_sticky", rd_obs, 32'h100);
    wr(2'd1, 32'h100);
    rd(2'd1);
    check_eq("ovf_cleared", rd_obs, 32'h0);

    // Push coinciding with pop while full.
    fill(4);
    in_port = 8'h00; idle(3);
    in_port = 8'h80; idle(L);
    rd(2'd3);
    check_eq("sim_pop", rd_obs, 32'h8000_0001);
    rd(2'd1);
    check_eq("sim_status", rd_obs, 32'h13);
    for (int i = 2; i <= 5; i++) begin
      rd(2'd3);
      check_eq($sformatf("sim_pop%0d", i), rd_obs, 32'h8000_0000 | ((i == 5) ? 32'h80 : 32'(i)));
    end

    // Empty read and mid-run reset.
    rd(2'd3);
    check_eq("empty_pop", rd_obs, 32'h0);
    rd(2'd1);
    check_eq("empty_status", rd_obs, 32'h0);
    fill(3);
    in_port = 8'h00; idle(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    rd(2'd1);
    check_eq("rst_status", rd_obs, 32'h0);
    rd(2'd2);
    check_eq("rst_mask", rd_obs, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) in_port = 8'($urandom);
      cyc(($urandom_range(199) == 0), 1'($urandom), ($urandom_range(2) != 0),
          ($urandom_range(3) != 0), 2'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
